// File: rtl/preamp_pkg.sv
// Shared types and constants for the LTC6912 preamp gain-programming controller.
// The command byte carries channel B gain in the upper nibble and channel A in the lower.
package preamp_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_REQ   = 3'd1,
      ST_SETUP = 3'd2,
      ST_SHIFT = 3'd3,
      ST_HOLD  = 3'd4,
      ST_DONE  = 3'd5
   } state_t;

   localparam int CMD_W      = 8;
   localparam int GAIN_W     = 4;
   localparam int GAIN_B_MSB = 7;
   localparam int GAIN_A_MSB = 3;

   localparam logic [GAIN_W-1:0] GAIN_X1 = 4'h1;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/preamp_spi_ctrl_sck_tick.sv
// Terminal-count divider: o_phase_tick pulses every (i_tc+1) cycles while i_en is high.
// The count restarts on each tick, so a new terminal count takes effect cleanly after a tick.
module preamp_sck_tick #(
   parameter int CNT_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_en,
   input  logic [CNT_W-1:0] i_tc,
   output logic             o_phase_tick
);

   logic [CNT_W-1:0] r_cnt;
   logic             w_at_tc;

   assign w_at_tc      = (r_cnt == i_tc);
   assign o_phase_tick = i_en && w_at_tc;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (!i_en || w_at_tc) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/preamp_spi_ctrl.sv
// Programs the LTC6912 gain byte over the shared SPI bus and captures the previous setting.
// One frame per accepted start; bus is requested for the whole frame and released with done.
module preamp_spi_ctrl
   import preamp_pkg::*;
#(
   parameter int CLK_DIV  = 4,
   parameter int CS_SETUP = 2,
   parameter int CS_HOLD  = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [GAIN_W-1:0] gain_a,
   input  logic [GAIN_W-1:0] gain_b,
   output logic              busy,
   output logic              done,
   output logic [CMD_W-1:0]  rdback,
   output logic              spi_req,
   input  logic              spi_gnt,
   output logic              amp_cs_n,
   output logic              spi_sck,
   output logic              spi_mosi,
   input  logic              amp_dout
);

   localparam int CNT_W = $clog2(max3(CLK_DIV, CS_SETUP, CS_HOLD)) + 1;
   localparam logic [CNT_W-1:0] TC_DIV   = CNT_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0] TC_SETUP = CNT_W'(CS_SETUP - 1);
   localparam logic [CNT_W-1:0] TC_HOLD  = CNT_W'(CS_HOLD - 1);

   state_t           r_state;
   logic [CMD_W-1:0] r_cmd;
   logic [CMD_W-1:0] r_sin;
   logic [2:0]       r_bit;
   logic             r_cs_n;
   logic             r_sck;
   logic             r_mosi;
   logic             r_req;
   logic             r_busy;
   logic             r_done;
   logic [CMD_W-1:0] r_rdback;

   state_t           w_state_nxt;
   logic [CMD_W-1:0] w_cmd_nxt;
   logic [CMD_W-1:0] w_sin_nxt;
   logic [2:0]       w_bit_nxt;
   logic             w_cs_n_nxt;
   logic             w_sck_nxt;
   logic             w_mosi_nxt;
   logic             w_req_nxt;
   logic             w_busy_nxt;
   logic             w_done_nxt;
   logic [CMD_W-1:0] w_rdback_nxt;

   logic             w_cnt_en;
   logic [CNT_W-1:0] w_tc;
   logic             w_tick;

   // One counter times setup, every SCK half-period and hold; its terminal count follows the state.
   always_comb begin
      w_cnt_en = 1'b0;
      w_tc     = TC_DIV;
      case (r_state)
         ST_SETUP: begin
            w_cnt_en = 1'b1;
            w_tc     = TC_SETUP;
         end
         ST_SHIFT: begin
            w_cnt_en = 1'b1;
            w_tc     = TC_DIV;
         end
         ST_HOLD: begin
            w_cnt_en = 1'b1;
            w_tc     = TC_HOLD;
         end
         default: begin
            w_cnt_en = 1'b0;
            w_tc     = TC_DIV;
         end
      endcase
   end

   preamp_sck_tick #(
      .CNT_W(CNT_W)
   ) u_sck_tick (
      .clk         (clk),
      .rst         (rst),
      .i_en        (w_cnt_en),
      .i_tc        (w_tc),
      .o_phase_tick(w_tick)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= ST_IDLE;
         r_cmd    <= '0;
         r_sin    <= '0;
         r_bit    <= 3'd7;
         r_cs_n   <= 1'b1;
         r_sck    <= 1'b0;
         r_mosi   <= 1'b0;
         r_req    <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_rdback <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_cmd    <= w_cmd_nxt;
         r_sin    <= w_sin_nxt;
         r_bit    <= w_bit_nxt;
         r_cs_n   <= w_cs_n_nxt;
         r_sck    <= w_sck_nxt;
         r_mosi   <= w_mosi_nxt;
         r_req    <= w_req_nxt;
         r_busy   <= w_busy_nxt;
         r_done   <= w_done_nxt;
         r_rdback <= w_rdback_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:  if (start)   w_state_nxt = ST_REQ;
         ST_REQ:   if (spi_gnt) w_state_nxt = ST_SETUP;
         ST_SETUP: if (w_tick)  w_state_nxt = ST_SHIFT;
         ST_SHIFT: if (w_tick && r_sck && (r_bit == 3'd0)) w_state_nxt = ST_HOLD;
         ST_HOLD:  if (w_tick)  w_state_nxt = ST_DONE;
         ST_DONE:  w_state_nxt = ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      w_cmd_nxt    = r_cmd;
      w_sin_nxt    = r_sin;
      w_bit_nxt    = r_bit;
      w_cs_n_nxt   = r_cs_n;
      w_sck_nxt    = r_sck;
      w_mosi_nxt   = r_mosi;
      w_req_nxt    = r_req;
      w_busy_nxt   = r_busy;
      w_done_nxt   = 1'b0;
      w_rdback_nxt = r_rdback;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_cmd_nxt[GAIN_B_MSB -: GAIN_W] = gain_b;
               w_cmd_nxt[GAIN_A_MSB -: GAIN_W] = gain_a;
               w_req_nxt  = 1'b1;
               w_busy_nxt = 1'b1;
            end
         end
         ST_REQ: begin
            if (spi_gnt) begin
               w_cs_n_nxt = 1'b0;
               w_mosi_nxt = r_cmd[CMD_W-1];
            end
         end
         ST_SETUP: begin
            if (w_tick) begin
               w_bit_nxt = 3'd7;
               w_sck_nxt = 1'b0;
            end
         end
         ST_SHIFT: begin
            // Rising SCK samples readback; falling SCK advances MOSI so it is centred on the next rise.
            if (w_tick) begin
               if (!r_sck) begin
                  w_sck_nxt        = 1'b1;
                  w_sin_nxt[r_bit] = amp_dout;
               end else begin
                  w_sck_nxt = 1'b0;
                  if (r_bit != 3'd0) begin
                     w_mosi_nxt = r_cmd[r_bit - 3'd1];
                     w_bit_nxt  = r_bit - 3'd1;
                  end
               end
            end
         end
         ST_HOLD: begin
            if (w_tick) begin
               w_cs_n_nxt   = 1'b1;
               w_sck_nxt    = 1'b0;
               w_mosi_nxt   = 1'b0;
               w_req_nxt    = 1'b0;
               w_rdback_nxt = r_sin;
               w_done_nxt   = 1'b1;
            end
         end
         ST_DONE: begin
            w_busy_nxt = 1'b0;
         end
         default: begin
            w_cs_n_nxt = 1'b1;
            w_sck_nxt  = 1'b0;
            w_mosi_nxt = 1'b0;
            w_req_nxt  = 1'b0;
            w_busy_nxt = 1'b0;
         end
      endcase
   end

   assign busy     = r_busy;
   assign done     = r_done;
   assign rdback   = r_rdback;
   assign spi_req  = r_req;
   assign amp_cs_n = r_cs_n;
   assign spi_sck  = r_sck;
   assign spi_mosi = r_mosi;

endmodule

// File: tb/tb_preamp_spi_ctrl.sv
// Bench for preamp_spi_ctrl: a default-timing and a minimum-timing instance share the stimulus
// and are compared every cycle against a frame-timeline model plus a few pinned literal results.
module tb_preamp_spi_ctrl;
   import preamp_pkg::*;

   logic       clk     = 1'b0;
   logic       rst     = 1'b1;
   logic       start   = 1'b0;
   logic       spi_gnt = 1'b0;
   logic [3:0] gain_a  = 4'h0;
   logic [3:0] gain_b  = 4'h0;

   logic [1:0] busy, done, spi_req, cs_n, sck, mosi, dout;
   logic [7:0] rdback [2];

   always #5 clk = ~clk;

   preamp_spi_ctrl u_dut (
      .clk(clk), .rst(rst), .start(start), .gain_a(gain_a), .gain_b(gain_b),
      .busy(busy[0]), .done(done[0]), .rdback(rdback[0]), .spi_req(spi_req[0]),
      .spi_gnt(spi_gnt), .amp_cs_n(cs_n[0]), .spi_sck(sck[0]), .spi_mosi(mosi[0]),
      .amp_dout(dout[0])
   );

   preamp_spi_ctrl #(.CLK_DIV(1), .CS_SETUP(1), .CS_HOLD(1)) u_dut_fast (
      .clk(clk), .rst(rst), .start(start), .gain_a(gain_a), .gain_b(gain_b),
      .busy(busy[1]), .done(done[1]), .rdback(rdback[1]), .spi_req(spi_req[1]),
      .spi_gnt(spi_gnt), .amp_cs_n(cs_n[1]), .spi_sck(sck[1]), .spi_mosi(mosi[1]),
      .amp_dout(dout[1])
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s[%0d] t=%0t: got %0h expected %0h", nm, inst, $time, act, exp);
      end
   endtask

   function automatic int p_setup(input int i); return (i == 0) ? 2 : 1; endfunction
   function automatic int p_div(input int i);   return (i == 0) ? 4 : 1; endfunction
   function automatic int p_hold(input int i);  return (i == 0) ? 2 : 1; endfunction
   function automatic int flen(input int i);
      return p_setup(i) + 16 * p_div(i) + p_hold(i);
   endfunction

   // Model: a frame is (accept, grant edge); every output follows from the cycle offset after grant.
   int         cyc = 0;
   bit         m_act [2] = '{0, 0};
   bit         m_gnt [2] = '{0, 0};
   int         m_e   [2] = '{0, 0};
   logic [7:0] m_cmd [2] = '{8'h00, 8'h00};
   logic [7:0] m_rd  [2] = '{8'h00, 8'h00};
   logic [7:0] rb_cur[2] = '{8'hA5, 8'hA5};

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 2; i++) begin
            m_act[i] <= 1'b0;
            m_gnt[i] <= 1'b0;
            m_rd[i]  <= 8'h00;
         end
      end else begin
         cyc <= cyc + 1;
         for (int i = 0; i < 2; i++) begin
            if (!m_act[i]) begin
               if (start) begin
                  m_act[i] <= 1'b1;
                  m_gnt[i] <= 1'b0;
                  m_cmd[i] <= {gain_b, gain_a};
               end
            end else if (!m_gnt[i]) begin
               if (spi_gnt) begin
                  m_gnt[i] <= 1'b1;
                  m_e[i]   <= cyc;
               end
            end else if (cyc - m_e[i] == flen(i)) begin
               m_rd[i] <= rb_cur[i];
            end else if (cyc - m_e[i] == flen(i) + 1) begin
               m_act[i] <= 1'b0;
            end
         end
      end
   end

   logic prev_sck_c [2] = '{1'b0, 1'b0};
   logic prev_mosi_c[2] = '{1'b0, 1'b0};

   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         logic eb, er, ec, es, em, ed;
         int   kk, n, ph;
         eb = 0; er = 0; ec = 1; es = 0; em = 0; ed = 0;
         if (m_act[i] && !m_gnt[i]) begin
            eb = 1; er = 1;
         end else if (m_act[i]) begin
            kk = cyc - m_e[i] - 1;
            eb = 1;
            if (kk < flen(i)) begin
               er = 1; ec = 0;
               ph = kk - p_setup(i);
               if (ph >= 0 && ph < 16 * p_div(i)) es = ((ph / p_div(i)) % 2) == 1;
               n = (ph < 0) ? 0 : ph / (2 * p_div(i));
               if (n > 7) n = 7;
               em = m_cmd[i][7 - n];
            end else begin
               ed = 1;
            end
         end
         chk("busy", i, 32'(busy[i]), 32'(eb));
         chk("spi_req", i, 32'(spi_req[i]), 32'(er));
         chk("amp_cs_n", i, 32'(cs_n[i]), 32'(ec));
         chk("spi_sck", i, 32'(sck[i]), 32'(es));
         chk("spi_mosi", i, 32'(mosi[i]), 32'(em));
         chk("done", i, 32'(done[i]), 32'(ed));
         chk("rdback", i, 32'(rdback[i]), 32'(m_rd[i]));
         if (sck[i] && !prev_sck_c[i]) chk("mosi_stable_at_rise", i, 32'(mosi[i]), 32'(prev_mosi_c[i]));
         prev_sck_c[i]  = sck[i];
         prev_mosi_c[i] = mosi[i];
      end
   end

   // Preamp stand-in: presents readback MSB first, advancing after each SCK rise; also records frames.
   int         cs_len    [2] = '{0, 0};
   int         rises     [2] = '{0, 0};
   logic [7:0] byte_acc  [2] = '{8'h00, 8'h00};
   int         last_len  [2] = '{0, 0};
   int         last_rises[2] = '{0, 0};
   logic [7:0] last_byte [2] = '{8'h00, 8'h00};
   int         done_cnt  [2] = '{0, 0};
   logic       prev_cs   [2] = '{1'b1, 1'b1};
   logic       prev_sck_m[2] = '{1'b0, 1'b0};

   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (cs_n[i]) begin
            if (!prev_cs[i]) begin
               last_len[i]   <= cs_len[i];
               last_rises[i] <= rises[i];
               last_byte[i]  <= byte_acc[i];
            end
            cs_len[i] <= 0;
            rises[i]  <= 0;
            dout[i]   <= rb_cur[i][7];
         end else begin
            cs_len[i] <= cs_len[i] + 1;
            if (sck[i] && !prev_sck_m[i]) begin
               rises[i]    <= rises[i] + 1;
               byte_acc[i] <= {byte_acc[i][6:0], mosi[i]};
               dout[i]     <= (rises[i] < 7) ? rb_cur[i][6 - rises[i]] : 1'b0;
            end
         end
         if (done[i]) done_cnt[i] <= done_cnt[i] + 1;
         prev_cs[i]    <= cs_n[i];
         prev_sck_m[i] <= sck[i];
      end
   end

   task automatic pulse_start();
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
   endtask

   task automatic wait_idle(input string nm);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while ((busy != 2'b00 || m_act[0] || m_act[1]) && n < 2000);
      @(negedge clk);
      checks++;
      if (n >= 2000) begin
         errors++;
         $display("FAIL %s: still busy after %0d cycles, required idle", nm, n);
      end
   endtask

   initial begin
      int d0, n;
      int gd, xt;

      repeat (3) @(negedge clk);
      chk("reset_cs_n", 0, 32'(cs_n), 32'(2'b11));
      chk("reset_busy", 0, 32'(busy), 32'(2'b00));
      chk("reset_rdback", 0, 32'(rdback[0]), 32'h00);
      rst = 1'b0;

      // Scenario 1: x1 gains, grant tied high, readback 0xA5.
      gain_a = GAIN_X1; gain_b = GAIN_X1; spi_gnt = 1'b1;
      rb_cur[0] = 8'hA5; rb_cur[1] = 8'hA5;
      pulse_start();
      wait_idle("s1");
      chk("s1_cs_low_cycles", 0, 32'(last_len[0]), 32'd68);
      chk("s1_cs_low_cycles", 1, 32'(last_len[1]), 32'd18);
      chk("s1_sck_rises", 0, 32'(last_rises[0]), 32'd8);
      chk("s1_sck_rises", 1, 32'(last_rises[1]), 32'd8);
      chk("s1_mosi_byte", 0, 32'(last_byte[0]), 32'h11);
      chk("s1_mosi_byte", 1, 32'(last_byte[1]), 32'h11);
      chk("s1_rdback", 0, 32'(rdback[0]), 32'hA5);
      chk("s1_rdback", 1, 32'(rdback[1]), 32'hA5);
      chk("s1_done_pulses", 0, 32'(done_cnt[0]), 32'd1);

      // Scenario 2: grant 10 cycles late.
      spi_gnt = 1'b0;
      pulse_start();
      for (int t = 0; t < 10; t++) begin
         chk("s2_req_wait", 0, 32'(spi_req[0]), 32'd1);
         chk("s2_cs_wait", 0, 32'(cs_n[0]), 32'd1);
         chk("s2_sck_wait", 0, 32'(sck[0]), 32'd0);
         if (t < 9) @(negedge clk);
      end
      spi_gnt = 1'b1;
      wait_idle("s2");
      chk("s2_cs_low_cycles", 0, 32'(last_len[0]), 32'd68);
      chk("s2_mosi_byte", 0, 32'(last_byte[0]), 32'h11);

      // Scenario 3: extra starts during SHIFT and in the DONE cycle are dropped.
      gain_a = 4'h2; gain_b = 4'h9;
      rb_cur[0] = 8'h3C; rb_cur[1] = 8'h3C;
      d0 = done_cnt[0];
      pulse_start();
      repeat (30) @(negedge clk);
      start = 1'b1; @(negedge clk); start = 1'b0;
      n = 0;
      while (!done[0] && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("s3_done_seen", 0, 32'(done[0]), 32'd1);
      start = 1'b1; @(negedge clk); start = 1'b0;
      wait_idle("s3");
      chk("s3_single_done", 0, 32'(done_cnt[0]), 32'(d0 + 1));
      chk("s3_mosi_byte", 0, 32'(last_byte[0]), 32'h92);
      chk("s3_rdback", 0, 32'(rdback[0]), 32'h3C);
      pulse_start();
      wait_idle("s3b");
      chk("s3_next_frame", 0, 32'(done_cnt[0]), 32'(d0 + 2));

      // Scenario 4: asynchronous reset in bit 4 of SHIFT.
      gain_a = GAIN_X1; gain_b = GAIN_X1;
      rb_cur[0] = 8'hA5; rb_cur[1] = 8'hA5;
      pulse_start();
      n = 0;
      while (cs_n[0] && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("s4_frame_began", 0, 32'(cs_n[0]), 32'd0);
      repeat (28) @(negedge clk);
      d0 = done_cnt[0];
      #2 rst = 1'b1;
      #1;
      chk("s4_async_cs_n", 0, 32'(cs_n[0]), 32'd1);
      chk("s4_async_sck", 0, 32'(sck[0]), 32'd0);
      chk("s4_async_busy", 0, 32'(busy[0]), 32'd0);
      chk("s4_async_req", 0, 32'(spi_req[0]), 32'd0);
      chk("s4_async_rdback", 0, 32'(rdback[0]), 32'h00);
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("s4_no_done", 0, 32'(done_cnt[0]), 32'(d0));
      pulse_start();
      wait_idle("s4");
      chk("s4_rdback_after", 0, 32'(rdback[0]), 32'hA5);

      // Scenario 5: gain inputs change right after acceptance.
      gain_a = GAIN_X1; gain_b = GAIN_X1;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0; gain_a = 4'hF; gain_b = 4'h7;
      wait_idle("s5");
      chk("s5_latched_byte", 0, 32'(last_byte[0]), 32'h11);
      chk("s5_latched_byte", 1, 32'(last_byte[1]), 32'h11);

      // Random frames: random gains/readback, late and wobbling grant, stray starts.
      for (int it = 0; it < 20; it++) begin
         gain_a = 4'($urandom_range(0, 15));
         gain_b = 4'($urandom_range(0, 15));
         rb_cur[0] = 8'($urandom_range(0, 255));
         rb_cur[1] = 8'($urandom_range(0, 255));
         gd = $urandom_range(0, 12);
         xt = $urandom_range(5, 90);
         spi_gnt = (gd == 0);
         @(negedge clk); start = 1'b1;
         for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            start = (t == xt);
            gain_a = 4'($urandom_range(0, 15));
            gain_b = 4'($urandom_range(0, 15));
            if (t >= gd) spi_gnt = (t < gd + 3) ? 1'b1 : ($urandom_range(0, 3) != 0);
         end
         start = 1'b0;
         spi_gnt = 1'b1;
         wait_idle("random");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/preamp_spi_ctrl.md
Name: preamp_spi_ctrl

Overview:
- Sequences one gain-programming transfer to the LTC6912 dual programmable preamp over the SPI bus, which is shared with the ADC.
- Triggered by a single-cycle start pulse, normally the debounced one-shot from the front-panel button.
- Requests the shared bus, shifts out the 8-bit gain command MSB first, and captures the 8-bit readback of the previous gain setting.
- Reports busy and done to the tuner top level.

Parameters:
- CLK_DIV, 4: clk cycles per SCK half-period; must be ≥1.
- CS_SETUP, 2: clk cycles from amp_cs_n falling to the first SCK low phase; must be ≥1.
- CS_HOLD, 2: clk cycles from the last SCK falling edge to amp_cs_n rising; must be ≥1.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- start  in  1  one-cycle request to program the gains
- gain_a  in  4  channel A gain code
- gain_b  in  4  channel B gain code
- busy  out  1  high from start acceptance until the done cycle, inclusive
- done  out  1  one-cycle pulse when the transfer is complete
- rdback  out  8  previous gain byte read from the preamp
- spi_req  out  1  shared-bus request to the SPI arbiter
- spi_gnt  in  1  bus grant from the SPI arbiter
- amp_cs_n  out  1  preamp chip select, active low
- spi_sck  out  1  SPI clock
- spi_mosi  out  1  serial data to the preamp
- amp_dout  in  1  serial readback from the preamp

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - State IDLE; amp_cs_n=1, spi_sck=0, spi_mosi=0, spi_req=0, busy=0, done=0, rdback=8'h00.
  - Applies equally mid-transfer: the frame is abandoned with no done pulse.
- All outputs are registered.
- FSM states: IDLE, REQ, SETUP, SHIFT, HOLD, DONE.
- IDLE:
  - start=1 latches cmd={gain_b,gain_a}, then goes to REQ with spi_req=1 and busy=1.
  - start is accepted only in IDLE. Pulses in any other state, including DONE, are dropped.
- REQ:
  - Waits for spi_gnt=1; amp_cs_n stays high meanwhile.
  - On grant: amp_cs_n=0, spi_mosi=cmd[7], go to SETUP.
- SETUP: lasts CS_SETUP cycles, then SHIFT.
- SHIFT: 8 bits, index i=7..0. Each bit is CLK_DIV cycles with SCK low, then CLK_DIV cycles with SCK high.
  - The clk edge that raises SCK also samples amp_dout into shift-in register bit i.
  - The edge that lowers SCK presents cmd[i-1] on spi_mosi. After the last bit, spi_mosi holds cmd[0].
  - spi_mosi is therefore stable for CLK_DIV cycles before and after each SCK rising edge.
  - Exactly 8 SCK rising edges per frame.
- HOLD:
  - Entered on the final SCK falling edge; lasts CS_HOLD cycles.
  - On exit: amp_cs_n=1, spi_req=0, rdback←shift-in register, go to DONE.
- DONE: done=1 for one cycle, busy=1, then IDLE with busy=0.
- Frame length: amp_cs_n is low for CS_SETUP+16·CLK_DIV+CS_HOLD cycles (68 with defaults).
- Bus ownership:
  - spi_req is held from REQ through HOLD.
  - A grant drop after REQ is ignored; the arbiter must not revoke a granted bus.
  - spi_sck and spi_mosi are driven only while amp_cs_n=0; otherwise they are 0.
- Input stability: gain_a and gain_b changes after acceptance do not affect the frame in progress.
- Counters: the divide counter is width clog2(max(CLK_DIV,CS_SETUP,CS_HOLD))+1, and the bit counter is 3 bits. Neither wraps within a frame.

Decomposition:
- Package preamp_pkg holds:
  - the FSM state encoding (3 bits);
  - the command layout constants (GAIN_B_MSB=7, GAIN_A_MSB=3, CMD_W=8);
  - the gain code constant GAIN_X1=4'h1, the tuner default.
- One natural sub-module, preamp_sck_tick:
  - a terminal-count divider producing phase_tick every CLK_DIV cycles while enabled;
  - it is cleared on enable low.
- The FSM and shift registers stay in preamp_spi_ctrl.

Test Plan:
1. Defaults, gain_a=1, gain_b=1, spi_gnt tied high, amp_dout driven with 0xA5 MSB-first at SCK rises, single start → spi_mosi bits 0,0,0,1,0,0,0,1; amp_cs_n low 68 cycles; 8 SCK rises; done pulse 1 cycle; rdback=0xA5; busy falls the cycle after done.
2. spi_gnt asserted 10 cycles after start → spi_req=1 and busy=1 throughout; amp_cs_n=1 and spi_sck=0 for those 10 cycles; frame then starts and is identical to scenario 1.
3. Second start pulses during SHIFT and in the DONE cycle → exactly one frame, one done pulse; next start in IDLE produces a new frame.
4. rst asserted at bit 4 of SHIFT → same-cycle asynchronous return to reset values; no done pulse; rdback=0x00; a following start completes normally.
5. gain_a/gain_b changed to 0xF/0x7 one cycle after acceptance → transmitted byte is still the latched 0x11.
6. CLK_DIV=1, CS_SETUP=1, CS_HOLD=1 → amp_cs_n low 18 cycles; spi_mosi changes never coincide with SCK rising; readback still correct.
